// File: rtl/iter_div32_pkg.sv
// iter_div32_pkg: shared width, counter size, state encodings and a magnitude helper for the divider.
package iter_div32_pkg;
    localparam int WIDTH = 32;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/iter_div32_if.sv
// iter_div32_if: execute-stage request/response bundle for the iterative divider.
interface iter_div32_if;
    import iter_div32_pkg::*;
    logic             div;
    logic             div_signed;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             complete;
    logic             busy;
    modport master (output div, div_signed, x, y, input s, r, complete, busy);
    modport slave (input div, div_signed, x, y, output s, r, complete, busy);
endinterface

// File: rtl/iter_div32_step.sv
// iter_div32_step: one restoring-division step, shift {rem,quo} left and keep the trial subtract if it does not borrow.
module iter_div32_step
    import iter_div32_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] trial;
    assign sh    = {rem_i, quo_i[WIDTH-1]};
    assign trial = {1'b0, sh} - {2'b00, dvs_i};
    assign rem_o = trial[WIDTH+1] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH+1]};
endmodule

// File: rtl/iter_div32.sv
// iter_div32: fixed-latency radix-2 restoring divider, signed/unsigned, sticky result until the next start.
module iter_div32
    import iter_div32_pkg::*;
(
    input  logic clk,
    input  logic reset,
    iter_div32_if.slave bus
);
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] s_q, s_d, r_q, r_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic             yz;

    iter_div32_step u_step (
        .rem_i(rem_q),
        .quo_i(quo_q),
        .dvs_i(dvs_q),
        .rem_o(rem_nx),
        .quo_o(quo_nx)
    );

    // A zero divisor runs the raw dividend unsigned: the loop then yields all-ones and leaves x as remainder.
    assign yz = (bus.y == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        s_d     = s_q;
        r_d     = r_q;
        if (bus.div) begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = mag(bus.x, bus.div_signed & ~yz);
            dvs_d   = mag(bus.y, bus.div_signed);
            qneg_d  = bus.div_signed & ~yz & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
            rneg_d  = bus.div_signed & ~yz & bus.x[WIDTH-1];
        end else if (state_q == CALC) begin
            if (cnt_q == CW'(WIDTH)) begin
                state_d = DONE;
                s_d     = qneg_q ? -quo_q : quo_q;
                r_d     = rneg_q ? -rem_q : rem_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                rem_d = rem_nx;
                quo_d = quo_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            s_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            s_q     <= s_d;
            r_q     <= r_d;
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.complete = (state_q == DONE);
    assign bus.busy     = (state_q == CALC);
endmodule
